// File: rtl/encoding_pkg.sv
// Shared types and helpers for the encoding loop scheduler.
//   sched_state_t : scheduler FSM states (IDLE -> RUN -> DONE -> IDLE)
//   idx_w(n)      : index width for a counter over n values, never below 1
package encoding_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up-counter used for the node and feature loops.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears count
//   clr     : synchronous clear (wins over inc)
//   inc     : advance by one this cycle
//   count   : current value, 0..MAX-1
//   wrap    : inc while count is at MAX-1 (count returns to 0 next edge)
module wrap_counter
  import encoding_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = idx_w(MAX)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  // With MAX=1 the counter sits at 0 and every inc is a wrap.
  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/encoding_loop_scheduler.sv
// Walks the encoding datapath over nodes (outer) x features (inner), one
// (node_idx, feat_idx) beat per valid/ready transfer, then pulses done.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   start        : begin a run (honoured only in IDLE)
//   abort        : cancel back to IDLE from any state, no done pulse
//   out_ready    : downstream accepts the current beat
//   out_valid    : beat valid (registered state only, independent of out_ready)
//   node_idx     : current node index
//   feat_idx     : current feature index
//   last_feat    : valid beat is the last feature of its node
//   last_node    : valid beat belongs to the last node
//   busy         : high in RUN and DONE
//   done         : one-cycle pulse after the final transfer
module encoding_loop_scheduler
  import encoding_pkg::*;
#(
  parameter int NUM_NODES    = 4,
  parameter int NUM_FEATURES = 6,
  parameter int NODE_W       = idx_w(NUM_NODES),
  parameter int FEAT_W       = idx_w(NUM_FEATURES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [NODE_W-1:0] node_idx,
  output logic [FEAT_W-1:0] feat_idx,
  output logic              last_feat,
  output logic              last_node,
  output logic              busy,
  output logic              done
);

  localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(NUM_NODES - 1);
  localparam logic [FEAT_W-1:0] FEAT_LAST = FEAT_W'(NUM_FEATURES - 1);

  sched_state_t      state, state_nxt;
  logic              transfer;
  logic              feat_wrap, node_wrap;
  logic              cnt_clr;
  logic [NODE_W-1:0] node_cnt;
  logic [FEAT_W-1:0] feat_cnt;

  assign out_valid = (state == RUN);
  assign transfer  = out_valid && out_ready;

  // node_wrap can only fire on the transfer of the very last beat.
  assign cnt_clr = abort || node_wrap;

  wrap_counter #(.MAX(NUM_FEATURES), .W(FEAT_W)) u_feat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (transfer),
    .count   (feat_cnt),
    .wrap    (feat_wrap)
  );

  wrap_counter #(.MAX(NUM_NODES), .W(NODE_W)) u_node_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (feat_wrap),
    .count   (node_cnt),
    .wrap    (node_wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (node_wrap) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  assign node_idx  = out_valid ? node_cnt : '0;
  assign feat_idx  = out_valid ? feat_cnt : '0;
  assign last_feat = out_valid && (feat_cnt == FEAT_LAST);
  assign last_node = out_valid && (node_cnt == NODE_LAST);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule
